// File: rtl/uart_pkg.sv
// uart_pkg: shared UART parity encodings, receiver state enum and parity helpers.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [1:0] PAR_NONE        = 2'b00;
    localparam logic [1:0] PAR_ODD         = 2'b01;
    localparam logic [1:0] PAR_EVEN        = 2'b10;
    localparam logic [1:0] PAR_ODD_NOFRAME = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    function automatic logic has_parity(input logic [1:0] cfg);
        return (cfg == PAR_ODD) || (cfg == PAR_EVEN);
    endfunction

    // Parity bit that makes the frame's total ones count match the configured sense.
    function automatic logic parity_bit(input logic [1:0] cfg, input logic [DATA_BITS-1:0] d);
        return (cfg == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for an asynchronous input that idles high.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst)
            {q, meta} <= 2'b11;
        else
            {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1/8P1 UART receiver sampling at bit centre, with parity and framing status.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic [1:0]           parity_type,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_n;
    logic [CW-1:0]        clk_cnt;
    logic [2:0]           bit_cnt;
    logic [1:0]           cfg;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 tick;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // The start bit is checked half a bit in; every later sample is a full bit apart.
    always_comb begin
        tick    = (state == START) ? (clk_cnt == HALF)
                                   : (state inside {DATA, PARITY, STOP}) && (clk_cnt == FULL);
        state_n = state;
        case (state)
            IDLE:      state_n = rx_s ? IDLE : START;
            START:     if (tick) state_n = rx_s ? IDLE : DATA;
            DATA:      if (tick && bit_cnt == LAST) state_n = has_parity(cfg) ? PARITY : STOP;
            PARITY:    if (tick) state_n = STOP;
            STOP:      if (tick) state_n = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            cfg        <= PAR_NONE;
            shreg      <= '0;
            par_bad    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            clk_cnt    <= (state == IDLE || tick) ? '0 : clk_cnt + 1'b1;
            if (state == IDLE) begin
                bit_cnt <= '0;
                if (!rx_s)
                    cfg <= parity_type;
            end
            if (tick && state == DATA) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (tick && state == PARITY)
                par_bad <= rx_s != parity_bit(cfg, shreg);
            if (tick && state == STOP) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                parity_err <= par_bad && has_parity(cfg);
                frame_err  <= !rx_s;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed UART frames checked against a frame-level reference model.
module tb_uart_rx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic [7:0] data_out;
    logic       data_valid, parity_err, frame_err, busy;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [7:0] hold_do = 8'h00;
    logic       hold_pe = 1'b0;
    logic       hold_fe = 1'b0;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .parity_type (parity_type),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every valid pulse must match the oldest outstanding frame; between pulses outputs hold.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 32'(data_valid), 0);
                end else begin
                    e = q.pop_front();
                    check("valid_cycle", cyc, e.cyc);
                    check("data_out", 32'(data_out), 32'(e.data));
                    check("parity_err", 32'(parity_err), 32'(e.pe));
                    check("frame_err", 32'(frame_err), 32'(e.fe));
                    check("busy_at_valid", 32'(busy), 32'(e.fe));
                    hold_do = e.data;
                    hold_pe = e.pe;
                    hold_fe = e.fe;
                end
            end else begin
                check("hold_data", 32'(data_out), 32'(hold_do));
                check("hold_perr", 32'(parity_err), 32'(hold_pe));
                check("hold_ferr", 32'(frame_err), 32'(hold_fe));
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic idle_clocks(input int n);
        rx_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb,
                              input logic stop, input int low_bits);
        exp_t x;
        bit   has_p;
        int   ones;
        has_p = (pt == 2'b01) || (pt == 2'b10);
        ones  = $countones(d) + int'(pb);
        x.cyc  = cyc + 1 + 2 + C / 2 + (9 + int'(has_p)) * C;
        x.data = d;
        x.pe   = has_p && ((pt == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1));
        x.fe   = !stop;
        q.push_back(x);
        parity_type = pt;
        drive_bit(1'b0);
        parity_type = 2'($urandom_range(0, 3));
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (has_p) drive_bit(pb);
        drive_bit(stop);
        if (!stop) begin
            repeat (low_bits) drive_bit(1'b0);
            drive_bit(1'b1);
        end
    endtask

    initial begin
        int         k;
        logic [7:0] d;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data_out), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_perr", 32'(parity_err), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        idle_clocks(2 * C);

        send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 0);
        send_frame(8'h03, 2'b01, 1'b1, 1'b1, 0);
        send_frame(8'h03, 2'b01, 1'b0, 1'b1, 0);
        send_frame(8'h07, 2'b10, 1'b1, 1'b1, 0);
        send_frame(8'h07, 2'b11, 1'b0, 1'b1, 0);
        send_frame(8'hE1, 2'b00, 1'b0, 1'b0, 20);
        send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 0);
        idle_clocks(C);

        // Short low glitch: START is entered, then rejected at the half-bit sample.
        k = cyc;
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        check("glitch_busy_hi", 32'(busy), 1);
        repeat (k + 12 - cyc) @(posedge clk);
        #1;
        check("glitch_busy_lo", 32'(busy), 0);
        idle_clocks(2 * C);

        // Reset in the middle of data bit 4 discards the frame.
        d = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_in = d[4];
        repeat (C / 2) @(posedge clk);
        #1;
        rst     = 1'b1;
        rx_in   = 1'b1;
        hold_do = 8'h00;
        hold_pe = 1'b0;
        hold_fe = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_data", 32'(data_out), 0);
        check("midrst_valid", 32'(data_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        idle_clocks(2 * C);
        send_frame(8'hC3, 2'b00, 1'b0, 1'b1, 0);

        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                       1'($urandom_range(0, 5) != 0), $urandom_range(0, 20));
            idle_clocks($urandom_range(0, 2 * C));
        end

        for (int i = 0; i < 4 * C && q.size() != 0; i++) @(posedge clk);
        idle_clocks(4);
        check("pending_frames", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
